id_ex_stage: RTL and testbench

- Pipeline register between the decode stage and the execute stage.
- Captures the decoded control bundles (wb/me/ex control, load flag, register addresses, operands, immediate) every cycle.
- Detects load-use hazards and inserts one bubble into EX while stalling fetch/decode.
- Handles branch flush from EX and whole-pipe hold from MEM.

---
 rtl/id_ex_stage.sv | 209 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between decode (ID) and execute (EX).
//
// Every cycle it captures the decoded control bundles, the load flag, the
// destination register, the operands, the immediate and the PC. It also:
//   - detects a load-use hazard and inserts one bubble into EX while it
//     stalls fetch/decode,
//   - loads a bubble when EX takes a branch (ex_flush),
//   - freezes completely while MEM is busy (mem_hold).
//
// Optional feature (macro ID_EX_BUBBLE_CNT_EN):
//   Adds output bubble_cnt[15:0]. This is a saturating count of the bubbles
//   inserted because of a load-use hazard. Flush bubbles and hold cycles are
//   not counted. Without the macro the port and the counter do not exist.
//
// Handshake: there is no valid/ready pair. The register advances on every
// rising edge unless mem_hold is high. stall_o is a combinational request to
// the upstream stages to keep the PC and the IF/ID register for this cycle.
//
// Ports:
//   clk, rst_n          clock; synchronous reset, active low
//   id_wb_cntrl         {skipW}
//   id_me_cntrl         {wr, pop, push, skipM}
//   id_ex_cntrl         {func[2:0], skipE}
//   id_load             decode holds a load (LDD)
//   id_rs1/id_rs2       source register addresses
//   id_uses_rs1/_rs2    the source is actually read
//   id_rd               destination register address
//   id_op1/op2/imm/pc   data fields
//   ex_flush            branch taken in EX; kill the instruction in decode
//   mem_hold            MEM is busy; freeze this register
//   ex_*                registered copies of the id_* bundle
//   stall_o             hold PC and IF/ID this cycle (combinational)
//   bubble_cnt          hazard bubble count (only with ID_EX_BUBBLE_CNT_EN)
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_wb_cntrl,
  input  logic [3:0]        id_me_cntrl,
  input  logic [3:0]        id_ex_cntrl,
  input  logic              id_load,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_op1,
  input  logic [DATA_W-1:0] id_op2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              ex_flush,
  input  logic              mem_hold,
  output logic              ex_wb_cntrl,
  output logic [3:0]        ex_me_cntrl,
  output logic [3:0]        ex_ex_cntrl,
  output logic              ex_load,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic              stall_o
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  // Bubble: every stage is skipped (skipW, skipM, skipE set, func 0).
  localparam logic       BUB_WB = 1'b1;
  localparam logic [3:0] BUB_ME = 4'b0001;
  localparam logic [3:0] BUB_EX = 4'b0001;

  // Load-use phase. RUN is the normal flow. BUBBLE marks the single cycle
  // in which a hazard bubble sits in EX.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } lu_state_e;

  lu_state_e state_q;
  lu_state_e state_d;

  logic src1_hit;
  logic src2_hit;
  logic hz;
  logic load_bubble;

  // The load in EX is real only when it is not already skipping MEM.
  // A load that skips MEM cannot produce the data late. r0 is an ordinary
  // register here, so the whole address is compared.
  assign src1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign src2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hz       = ex_load && !ex_me_cntrl[0] && (src1_hit || src2_hit);

  // A flush redirects fetch, so it cancels any stall. This is also true
  // during a hold, because the flush source keeps asserting until the hold
  // drops.
  assign stall_o = (hz || mem_hold) && !ex_flush;

  // Under mem_hold this value is ignored. Otherwise a flush or a hazard
  // replaces the decode contents with a bubble.
  assign load_bubble = ex_flush || hz;

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_wb_cntrl <= BUB_WB;
      ex_me_cntrl <= BUB_ME;
      ex_ex_cntrl <= BUB_EX;
      ex_load     <= 1'b0;
      ex_rd       <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else if (mem_hold) begin
      ex_wb_cntrl <= ex_wb_cntrl;
      ex_me_cntrl <= ex_me_cntrl;
      ex_ex_cntrl <= ex_ex_cntrl;
      ex_load     <= ex_load;
      ex_rd       <= ex_rd;
      ex_op1      <= ex_op1;
      ex_op2      <= ex_op2;
      ex_imm      <= ex_imm;
      ex_pc       <= ex_pc;
    end else if (load_bubble) begin
      ex_wb_cntrl <= BUB_WB;
      ex_me_cntrl <= BUB_ME;
      ex_ex_cntrl <= BUB_EX;
      ex_load     <= 1'b0;
      ex_rd       <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else begin
      ex_wb_cntrl <= id_wb_cntrl;
      ex_me_cntrl <= id_me_cntrl;
      ex_ex_cntrl <= id_ex_cntrl;
      ex_load     <= id_load;
      ex_rd       <= id_rd;
      ex_op1      <= id_op1;
      ex_op2      <= id_op2;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // BUBBLE never lasts longer than one cycle. The bubble carries load=0, so
  // the hazard cannot fire again. Only a hold keeps the FSM in BUBBLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (hz && !mem_hold) begin
          state_d = ST_BUBBLE;
        end
      end
      ST_BUBBLE: begin
        if (!mem_hold) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // ---------------------------------------------------------------------------
  // Hazard bubble counter (saturating)
  // ---------------------------------------------------------------------------
  logic [15:0] cnt_q;
  logic        hz_bubble;

  // Count only the edges where the hazard is the reason a bubble is loaded.
  assign hz_bubble = hz && !ex_flush && !mem_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else if (hz_bubble && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed test bench for id_ex_stage.
//
// Each step drives one set of decode inputs shortly after a rising edge.
// Each step also pushes two entries:
//   - the expected stall_o for that cycle. The monitor checks it at the
//     falling edge.
//   - the expected registered EX bundle after the next rising edge. The
//     monitor checks it 1 ns after that edge.
// All expected values are written out by hand in the step list.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int W      = 1 + 4 + 4 + 1 + REG_AW + 4 * DATA_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              id_wb_cntrl = 1'b0;
  logic [3:0]        id_me_cntrl = '0;
  logic [3:0]        id_ex_cntrl = '0;
  logic              id_load = 1'b0;
  logic [REG_AW-1:0] id_rs1 = '0;
  logic [REG_AW-1:0] id_rs2 = '0;
  logic              id_uses_rs1 = 1'b0;
  logic              id_uses_rs2 = 1'b0;
  logic [REG_AW-1:0] id_rd = '0;
  logic [DATA_W-1:0] id_op1 = '0;
  logic [DATA_W-1:0] id_op2 = '0;
  logic [DATA_W-1:0] id_imm = '0;
  logic [DATA_W-1:0] id_pc = '0;
  logic              ex_flush = 1'b0;
  logic              mem_hold = 1'b0;
  logic              ex_wb_cntrl;
  logic [3:0]        ex_me_cntrl;
  logic [3:0]        ex_ex_cntrl;
  logic              ex_load;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc;
  logic              stall_o;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0]       bubble_cnt;
`endif

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_wb_cntrl (id_wb_cntrl),
    .id_me_cntrl (id_me_cntrl),
    .id_ex_cntrl (id_ex_cntrl),
    .id_load     (id_load),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .id_op1      (id_op1),
    .id_op2      (id_op2),
    .id_imm      (id_imm),
    .id_pc       (id_pc),
    .ex_flush    (ex_flush),
    .mem_hold    (mem_hold),
    .ex_wb_cntrl (ex_wb_cntrl),
    .ex_me_cntrl (ex_me_cntrl),
    .ex_ex_cntrl (ex_ex_cntrl),
    .ex_load     (ex_load),
    .ex_rd       (ex_rd),
    .ex_op1      (ex_op1),
    .ex_op2      (ex_op2),
    .ex_imm      (ex_imm),
    .ex_pc       (ex_pc),
    .stall_o     (stall_o)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt  (bubble_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           exp_tag_q[$];
  logic [1:0]   stall_q[$];   // {check, value}
  int           stall_tag_q[$];
  int           total = 0;
  int           bad = 0;
  int           step_no = 0;

  function automatic logic [W-1:0] pk(input logic wb, input logic [3:0] me,
                                      input logic [3:0] ex, input logic ld,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [DATA_W-1:0] o1,
                                      input logic [DATA_W-1:0] o2,
                                      input logic [DATA_W-1:0] im,
                                      input logic [DATA_W-1:0] pc);
    return {wb, me, ex, ld, rd, o1, o2, im, pc};
  endfunction

  logic [W-1:0] bub;
  initial bub = pk(1'b1, 4'b0001, 4'b0001, 1'b0, '0, '0, '0, '0, '0);

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input logic rst, input logic wb, input logic [3:0] me,
                      input logic [3:0] ex, input logic ld,
                      input logic [2:0] rs1, input logic u1,
                      input logic [2:0] rs2, input logic u2,
                      input logic [2:0] rd, input logic [15:0] o1,
                      input logic [15:0] o2, input logic [15:0] im,
                      input logic [15:0] pc, input logic fl, input logic hd,
                      input logic chk_s, input logic exp_s,
                      input logic [W-1:0] exp_r);
    @(posedge clk);
    #2;
    step_no++;
    rst_n       = rst;
    id_wb_cntrl = wb;
    id_me_cntrl = me;
    id_ex_cntrl = ex;
    id_load     = ld;
    id_rs1      = rs1;
    id_uses_rs1 = u1;
    id_rs2      = rs2;
    id_uses_rs2 = u2;
    id_rd       = rd;
    id_op1      = o1;
    id_op2      = o2;
    id_imm      = im;
    id_pc       = pc;
    ex_flush    = fl;
    mem_hold    = hd;
    stall_q.push_back({chk_s, exp_s});
    stall_tag_q.push_back(step_no);
    exp_q.push_back(exp_r);
    exp_tag_q.push_back(step_no);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (stall_q.size() > 0) begin
      logic [1:0] e;
      int t;
      e = stall_q.pop_front();
      t = stall_tag_q.pop_front();
      if (e[1]) begin
        total++;
        if (stall_o !== e[0]) begin
          bad++;
          $display("FAIL stall_o step %0d: got=%b exp=%b", t, stall_o, e[0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      int t;
      e = exp_q.pop_front();
      t = exp_tag_q.pop_front();
      a = {ex_wb_cntrl, ex_me_cntrl, ex_ex_cntrl, ex_load, ex_rd,
           ex_op1, ex_op2, ex_imm, ex_pc};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ex_regs step %0d: got=%h exp=%h", t, a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] ld_l;

  initial begin
    // Reset with random decode contents. In the first cycle the flush forces
    // stall_o low even though the EX registers are still unknown.
    step(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
         3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
         16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
         1'b1, 1'b0, 1'b1, 1'b0, bub);
    step(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
         3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
         16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
         1'b0, 1'b0, 1'b1, 1'b0, bub);

    // Pass-through of a SUB instruction.
    step(1, 0, 4'b0000, 4'b0100, 0, 0, 0, 0, 0, 2, 16'h0005, 16'h0003, 16'h0011, 16'h0100,
         0, 0, 1, 0, pk(0, 4'b0000, 4'b0100, 0, 2, 16'h0005, 16'h0003, 16'h0011, 16'h0100));
    // Load-use on rs1: LDD r3, then ADD reading r3 stalls once.
    step(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 3, 16'h0020, 16'h0000, 16'h0004, 16'h0101,
         0, 0, 1, 0, pk(0, 4'b0000, 4'b0000, 1, 3, 16'h0020, 16'h0000, 16'h0004, 16'h0101));
    step(1, 0, 4'b0001, 4'b0000, 0, 3, 1, 0, 0, 4, 16'h0007, 16'h0008, 16'h0000, 16'h0102,
         0, 0, 1, 1, bub);
    step(1, 0, 4'b0001, 4'b0000, 0, 3, 1, 0, 0, 4, 16'h0007, 16'h0008, 16'h0000, 16'h0102,
         0, 0, 1, 0, pk(0, 4'b0001, 4'b0000, 0, 4, 16'h0007, 16'h0008, 16'h0000, 16'h0102));
    // rs1 matches but is not read; rs2 is read but does not match: no stall.
    step(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0103,
         0, 0, 1, 0, pk(0, 4'b0000, 4'b0000, 1, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0103));
    step(1, 0, 4'b0001, 4'b0010, 0, 3, 0, 5, 1, 5, 16'h0009, 16'h0000, 16'h0000, 16'h0104,
         0, 0, 1, 0, pk(0, 4'b0001, 4'b0010, 0, 5, 16'h0009, 16'h0000, 16'h0000, 16'h0104));
    // r0 is a real register: LDD r0 followed by a read of r0 via rs2.
    step(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0, 16'h0030, 16'h0000, 16'h0000, 16'h0105,
         0, 0, 1, 0, pk(0, 4'b0000, 4'b0000, 1, 0, 16'h0030, 16'h0000, 16'h0000, 16'h0105));
    step(1, 1, 4'b0001, 4'b1000, 0, 6, 0, 0, 1, 7, 16'h000a, 16'h000b, 16'h000c, 16'h0106,
         0, 0, 1, 1, bub);
    step(1, 1, 4'b0001, 4'b1000, 0, 6, 0, 0, 1, 7, 16'h000a, 16'h000b, 16'h000c, 16'h0106,
         0, 0, 1, 0, pk(1, 4'b0001, 4'b1000, 0, 7, 16'h000a, 16'h000b, 16'h000c, 16'h0106));
    // A load whose skipM is set cannot cause a hazard.
    step(1, 0, 4'b0001, 4'b0000, 1, 0, 0, 0, 0, 6, 16'h0000, 16'h0000, 16'h0000, 16'h0107,
         0, 0, 1, 0, pk(0, 4'b0001, 4'b0000, 1, 6, 16'h0000, 16'h0000, 16'h0000, 16'h0107));
    step(1, 0, 4'b0000, 4'b0110, 0, 6, 1, 6, 1, 1, 16'h0011, 16'h0022, 16'h0000, 16'h0108,
         0, 0, 1, 0, pk(0, 4'b0000, 4'b0110, 0, 1, 16'h0011, 16'h0022, 16'h0000, 16'h0108));
    // Flush together with a hazard: the flush wins and stall_o stays low.
    step(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0005, 16'h0109,
         0, 0, 1, 0, pk(0, 4'b0000, 4'b0000, 1, 1, 16'h0000, 16'h0000, 16'h0005, 16'h0109));
    step(1, 0, 4'b1000, 4'b0010, 0, 1, 1, 0, 0, 2, 16'h0033, 16'h0044, 16'h0000, 16'h010a,
         1, 0, 1, 0, bub);
    step(1, 0, 4'b0000, 4'b0000, 0, 1, 1, 0, 0, 2, 16'h0055, 16'h0000, 16'h0000, 16'h0200,
         0, 0, 1, 0, pk(0, 4'b0000, 4'b0000, 0, 2, 16'h0055, 16'h0000, 16'h0000, 16'h0200));
    // Hold: the EX bundle stays frozen while the inputs and the flush change.
    ld_l = pk(0, 4'b0000, 4'b0000, 1, 2, 16'h0066, 16'h0000, 16'h0008, 16'h0201);
    step(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 2, 16'h0066, 16'h0000, 16'h0008, 16'h0201,
         0, 0, 1, 0, ld_l);
    step(1, 0, 4'b0000, 4'b0000, 0, 2, 1, 0, 0, 3, 16'h0077, 16'h0000, 16'h0000, 16'h0202,
         0, 1, 1, 1, ld_l);
    step(1, 1, 4'b1010, 4'b1100, 0, 4, 0, 5, 0, 4, 16'h0123, 16'h0456, 16'h0789, 16'h0203,
         0, 1, 1, 1, ld_l);
    step(1, 1, 4'b1111, 4'b1110, 1, 4, 0, 5, 0, 6, 16'h0088, 16'h0099, 16'h00aa, 16'h0300,
         1, 1, 1, 0, ld_l);
    step(1, 0, 4'b0100, 4'b0010, 0, 2, 1, 2, 1, 7, 16'h00bb, 16'h00cc, 16'h00dd, 16'h0301,
         1, 1, 1, 0, ld_l);
    // The hold drops with the flush still asserted, so EX receives a bubble.
    step(1, 0, 4'b0000, 4'b0000, 0, 2, 1, 0, 0, 3, 16'h0077, 16'h0000, 16'h0000, 16'h0202,
         1, 0, 1, 0, bub);
    step(1, 0, 4'b0001, 4'b0100, 0, 2, 1, 0, 0, 3, 16'h0012, 16'h0034, 16'h0056, 16'h0400,
         0, 0, 1, 0, pk(0, 4'b0001, 4'b0100, 0, 3, 16'h0012, 16'h0034, 16'h0056, 16'h0400));
    // Third load-use hazard, this time on rs2.
    step(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 5, 16'h0000, 16'h0000, 16'h0000, 16'h0401,
         0, 0, 1, 0, pk(0, 4'b0000, 4'b0000, 1, 5, 16'h0000, 16'h0000, 16'h0000, 16'h0401));
    step(1, 0, 4'b0001, 4'b0010, 0, 0, 0, 5, 1, 6, 16'h0001, 16'h0002, 16'h0003, 16'h0402,
         0, 0, 1, 1, bub);
    step(1, 0, 4'b0001, 4'b0010, 0, 0, 0, 5, 1, 6, 16'h0001, 16'h0002, 16'h0003, 16'h0402,
         0, 0, 1, 0, pk(0, 4'b0001, 4'b0010, 0, 6, 16'h0001, 16'h0002, 16'h0003, 16'h0402));
`ifdef ID_EX_BUBBLE_CNT_EN
    // Three hazard bubbles so far; the flush bubbles and hold cycles do not count.
    @(posedge clk);
    #1;
    total++;
    if (bubble_cnt !== 16'd3) begin
      bad++;
      $display("FAIL bubble_cnt: got=%0d exp=3", bubble_cnt);
    end
`endif
    // Reset takes priority over a concurrent hold.
    step(0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 5, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
         0, 1, 1, 1, bub);
    step(1, 0, 4'b0010, 4'b1010, 0, 1, 1, 2, 1, 3, 16'hbeef, 16'hcafe, 16'h0f0f, 16'h0500,
         0, 0, 1, 0, pk(0, 4'b0010, 4'b1010, 0, 3, 16'hbeef, 16'hcafe, 16'h0f0f, 16'h0500));

    @(posedge clk);
    #3;
    @(posedge clk);
    #3;
`ifdef ID_EX_BUBBLE_CNT_EN
    total++;
    if (bubble_cnt !== 16'd0) begin
      bad++;
      $display("FAIL bubble_cnt_after_reset: got=%0d exp=0", bubble_cnt);
    end
`endif
    total++;
    if (exp_q.size() != 0 || stall_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained: got=%0d/%0d exp=0/0", exp_q.size(), stall_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
